// File: rtl/layer6_pixel_bank_buffer_pkg.sv
// Shared CNN definitions for the layer-6 pixel buffer: default geometry,
// buffer state encoding and the pooled-dimension end constant.
package layer6_pixel_bank_buffer_pkg;

  localparam int L6_DATA_W       = 128;
  localparam int L6_IN_DIM       = 16;
  localparam int L6_ADDR_W       = 16;
  localparam int L6_POOL_COL_END = L6_IN_DIM / 2 - 1;

  typedef enum logic {
    FILL  = 1'b0,
    READY = 1'b1
  } buf_state_e;

endpackage

// File: rtl/counter_cnn.sv
// Generic CNN event counter: clear has priority, keep holds the value,
// otherwise the count advances by one per cycle.
module counter_cnn #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         keep_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  // count register with clear/keep priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {W{1'b0}};
    end else if (clear_i) begin
      count_q <= {W{1'b0}};
    end else if (!keep_i) begin
      count_q <= count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_q <= count_q;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/layer6_pixel_bank_buffer_ram.sv
// One parity bank: synchronous write, registered read that can be forced
// to zero for out-of-range pooled coordinates. Contents are never reset.
module pixel_bank_ram #(
  parameter  int DEPTH  = 64,
  parameter  int DATA_W = 128,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic              rzero_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // storage write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // registered read port, holds when no request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= {DATA_W{1'b0}};
    end else if (re_i) begin
      rdata_q <= rzero_i ? {DATA_W{1'b0}} : mem_q[raddr_i];
    end else begin
      rdata_q <= rdata_q;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/layer6_pixel_bank_buffer.sv
// Frame buffer between layer-5 output and layer-6 2x2 max pooling: four
// row/col parity banks so one pooled read returns the whole 2x2 window.
module layer6_pixel_bank_buffer
  import layer6_pixel_bank_buffer_pkg::*;
#(
  parameter int DATA_W = L6_DATA_W,
  parameter int IN_DIM = L6_IN_DIM,
  parameter int ADDR_W = L6_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              save_enable,
  input  logic [ADDR_W-1:0] save_row,
  input  logic [ADDR_W-1:0] save_col,
  input  logic [DATA_W-1:0] save_data,
  input  logic              read_pixel_signal,
  input  logic [ADDR_W-1:0] read_row_addr,
  input  logic [ADDR_W-1:0] read_col_addr,
  input  logic              frame_release,
  output logic [DATA_W-1:0] input_data_even_even,
  output logic [DATA_W-1:0] input_data_even_odd,
  output logic [DATA_W-1:0] input_data_odd_even,
  output logic [DATA_W-1:0] input_data_odd_odd,
  output logic              pixel_store_done,
  output logic              frame_ready,
  output logic              write_error
);

  localparam int POOL  = IN_DIM / 2;
  localparam int DEPTH = POOL * POOL;
  localparam int AW    = $clog2(DEPTH);
  localparam int TOTAL = IN_DIM * IN_DIM;

  buf_state_e        state_q;
  logic              done_q;
  logic              ready_q;
  logic              err_q;
  logic [15:0]       count_s;
  logic              wr_in_range_s;
  logic              wr_ok_s;
  logic              wr_last_s;
  logic              release_s;
  logic              rd_zero_s;
  logic [AW-1:0]     waddr_s;
  logic [AW-1:0]     raddr_s;
  logic [DATA_W-1:0] bank_rd_s [4];

  assign wr_in_range_s = (save_row < ADDR_W'(IN_DIM)) && (save_col < ADDR_W'(IN_DIM));
  assign wr_ok_s       = save_enable && wr_in_range_s && (state_q == FILL);
  assign wr_last_s     = wr_ok_s && (count_s == 16'(TOTAL - 1));
  assign release_s     = frame_release && (state_q == READY);
  assign rd_zero_s     = (read_row_addr >= ADDR_W'(POOL)) || (read_col_addr >= ADDR_W'(POOL));

  // The pixel's position inside its 2x2 window picks the bank; the window
  // coordinate picks the word, so all four banks share one read address.
  assign waddr_s = AW'((save_row >> 1) * ADDR_W'(POOL) + (save_col >> 1));
  assign raddr_s = AW'(read_row_addr * ADDR_W'(POOL) + read_col_addr);

  counter_cnn #(.W(16)) u_wr_count (
    .clk     (clk),
    .rst     (rst),
    .clear_i (release_s),
    .keep_i  (!wr_ok_s),
    .count_o (count_s)
  );

  for (genvar b = 0; b < 4; b++) begin : g_bank
    pixel_bank_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we_i    (wr_ok_s && ({save_row[0], save_col[0]} == 2'(b))),
      .waddr_i (waddr_s),
      .wdata_i (save_data),
      .re_i    (read_pixel_signal),
      .rzero_i (rd_zero_s),
      .raddr_i (raddr_s),
      .rdata_o (bank_rd_s[b])
    );
  end

  // fill/ready sequencing with registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (save_enable && (!wr_in_range_s || (state_q == READY))) begin
        err_q <= 1'b1;
      end else begin
        err_q <= err_q;
      end
      case (state_q)
        FILL: begin
          if (wr_last_s) begin
            state_q <= READY;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            state_q <= FILL;
            ready_q <= 1'b0;
          end
        end
        READY: begin
          if (frame_release) begin
            state_q <= FILL;
            ready_q <= 1'b0;
          end else begin
            state_q <= READY;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= FILL;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign input_data_even_even = bank_rd_s[0];
  assign input_data_even_odd  = bank_rd_s[1];
  assign input_data_odd_even  = bank_rd_s[2];
  assign input_data_odd_odd   = bank_rd_s[3];
  assign pixel_store_done     = done_q;
  assign frame_ready          = ready_q;
  assign write_error          = err_q;

endmodule

// File: tb/tb_layer6_pixel_bank_buffer.sv
// Self-checking bench: directed frames from the test plan plus randomized
// frames, compared every cycle against a 2D-array frame model.
module tb_layer6_pixel_bank_buffer;

  localparam int DW = 128;
  localparam int N  = 16;
  localparam int P  = N / 2;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          save_enable;
  logic [AW-1:0] save_row, save_col;
  logic [DW-1:0] save_data;
  logic          read_pixel_signal;
  logic [AW-1:0] read_row_addr, read_col_addr;
  logic          frame_release;
  logic [DW-1:0] ee, eo, oe, oo;
  logic          pixel_store_done, frame_ready, write_error;

  always #5 clk = ~clk;

  layer6_pixel_bank_buffer dut (
    .clk                  (clk),
    .rst                  (rst),
    .save_enable          (save_enable),
    .save_row             (save_row),
    .save_col             (save_col),
    .save_data            (save_data),
    .read_pixel_signal    (read_pixel_signal),
    .read_row_addr        (read_row_addr),
    .read_col_addr        (read_col_addr),
    .frame_release        (frame_release),
    .input_data_even_even (ee),
    .input_data_even_odd  (eo),
    .input_data_odd_even  (oe),
    .input_data_odd_odd   (oo),
    .pixel_store_done     (pixel_store_done),
    .frame_ready          (frame_ready),
    .write_error          (write_error)
  );

  // frame model: plain 2D picture plus status
  logic [DW-1:0] pix [N][N];
  bit            m_ready, m_err, m_done;
  int            m_cnt;
  logic [DW-1:0] m_ee, m_eo, m_oe, m_oo;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ready = 0; m_err = 0; m_done = 0; m_cnt = 0;
    m_ee = '0; m_eo = '0; m_oe = '0; m_oo = '0;
  endtask

  task automatic check_all();
    check_val("store_done", {127'd0, pixel_store_done}, {127'd0, m_done});
    check_val("frame_ready", {127'd0, frame_ready}, {127'd0, m_ready});
    check_val("write_error", {127'd0, write_error}, {127'd0, m_err});
    check_val("out_ee", ee, m_ee);
    check_val("out_eo", eo, m_eo);
    check_val("out_oe", oe, m_oe);
    check_val("out_oo", oo, m_oo);
  endtask

  // predict one clock edge from current inputs, then compare after it
  task automatic cycle();
    bit old_ready;
    int r, c;
    old_ready = m_ready;
    m_done = 0;
    if (read_pixel_signal) begin
      r = int'(read_row_addr);
      c = int'(read_col_addr);
      if (r < P && c < P) begin
        m_ee = pix[2*r][2*c];     m_eo = pix[2*r][2*c+1];
        m_oe = pix[2*r+1][2*c];   m_oo = pix[2*r+1][2*c+1];
      end else begin
        m_ee = '0; m_eo = '0; m_oe = '0; m_oo = '0;
      end
    end
    if (save_enable) begin
      if (!old_ready && save_row < N && save_col < N) begin
        pix[save_row][save_col] = save_data;
        m_cnt++;
        if (m_cnt == N * N) begin
          m_ready = 1;
          m_done  = 1;
        end
      end else begin
        m_err = 1;
      end
    end
    if (old_ready && frame_release) begin
      m_ready = 0;
      m_cnt   = 0;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    save_enable = 0; read_pixel_signal = 0; frame_release = 0;
  endtask

  task automatic wr(input int r, input int c, input logic [DW-1:0] d);
    save_enable = 1; save_row = AW'(r); save_col = AW'(c); save_data = d;
    cycle();
    save_enable = 0;
  endtask

  task automatic rd(input int r, input int c);
    read_pixel_signal = 1; read_row_addr = AW'(r); read_col_addr = AW'(c);
    cycle();
    read_pixel_signal = 0;
  endtask

  task automatic rel();
    frame_release = 1;
    cycle();
    frame_release = 0;
  endtask

  function automatic logic [DW-1:0] lanes(input int v);
    return {8{16'(v)}};
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic raster(input int offs);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        wr(r, c, lanes(r * 16 + c + offs));
  endtask

  // random-order frame with idles, stray writes and reads mixed in
  task automatic random_frame();
    int ord [N*N];
    int j, t, k;
    for (int i = 0; i < N * N; i++) ord[i] = i;
    for (int i = N * N - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = ord[i]; ord[i] = ord[j]; ord[j] = t;
    end
    k = 0;
    while (k < N * N) begin
      case ($urandom_range(9, 0))
        0: cycle();
        1: wr(int'($urandom_range(20, 16)), int'($urandom_range(N - 1, 0)), rnd_word());
        2: rd(int'($urandom_range(P + 1, 0)), int'($urandom_range(P + 1, 0)));
        3: rel();
        default: begin
          wr(ord[k] / N, ord[k] % N, rnd_word());
          k++;
        end
      endcase
    end
    for (int i = 0; i < 24; i++) begin
      if (i == 10) wr(int'($urandom_range(N - 1, 0)), int'($urandom_range(N - 1, 0)), rnd_word());
      else rd(int'($urandom_range(P + 1, 0)), int'($urandom_range(P + 1, 0)));
    end
    rel();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    save_row = '0; save_col = '0; save_data = '0;
    read_row_addr = '0; read_col_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // frame 1: raster, then window reads
    raster(0);
    cycle();
    rd(3, 5);
    check_val("pool35_ee", ee, lanes(16'h6A));
    check_val("pool35_eo", eo, lanes(16'h6B));
    check_val("pool35_oe", oe, lanes(16'h7A));
    check_val("pool35_oo", oo, lanes(16'h7B));
    rd(7, 7);
    check_val("pool77_ee", ee, lanes(16'hEE));
    check_val("pool77_oo", oo, lanes(16'hFF));
    cycle();

    // write while READY is dropped
    wr(0, 0, {DW{1'b1}});
    rd(0, 0);
    check_val("ready_wr_drop", ee, lanes(0));
    check_val("ready_wr_err", {127'd0, write_error}, {127'd0, 1'b1});

    // release, second frame with data+1
    rel();
    check_val("release_ready", {127'd0, frame_ready}, 128'd0);
    raster(1);
    rd(0, 0);
    check_val("frame2_ee", ee, lanes(1));
    rel();

    // out-of-range write mid-frame, then out-of-range pooled read
    for (int i = 0; i < 40; i++) wr(i / N, i % N, rnd_word());
    wr(16, 0, rnd_word());
    for (int i = 40; i < N * N; i++) wr(i / N, i % N, rnd_word());
    rd(8, 0);
    check_val("pool80_zero", ee | eo | oe | oo, '0);
    rel();

    // reset after 100 writes, then a full frame counts from zero
    for (int i = 0; i < 100; i++) wr(i / N, i % N, rnd_word());
    rd(1, 1);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N * N; i++) wr(i / N, i % N, rnd_word());
    rel();

    // randomized frames
    for (int f = 0; f < 3; f++) random_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/layer6_pixel_bank_buffer.md
Name: layer6_pixel_bank_buffer

Overview:
- Frame buffer between the layer-5 output stage and the layer-6 2x2 max-pooling stage.
- Accepts layer-5 pixels (all channels packed in one word) by row/col and stores them in four parity banks: even/even, even/odd, odd/even, odd/odd.
- Signals the pooling stage when a full frame is stored, then serves its reads: one pooled coordinate returns all four window pixels in a single access.
- Frees the frame for the next write pass when the pooling stage reports completion.

Parameters:
- DATA_W, 128, packed pixel width (8 channels x 16 bit); equals the layer-6 input width define.
- IN_DIM, 16, input frame height = width; must be even. Pooled dimension is IN_DIM/2.
- ADDR_W, 16, width of all row/col address ports (the codebase word length).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- save_enable  in  1  layer-5 write strobe
- save_row  in  ADDR_W  input-frame row of the write
- save_col  in  ADDR_W  input-frame column of the write
- save_data  in  DATA_W  pixel word to store
- read_pixel_signal  in  1  read request from the pooling stage
- read_row_addr  in  ADDR_W  pooled row (0..IN_DIM/2-1)
- read_col_addr  in  ADDR_W  pooled column (0..IN_DIM/2-1)
- frame_release  in  1  pooling finished; connect to layer6_calculation_done
- input_data_even_even  out  DATA_W  pixel (2r, 2c)
- input_data_even_odd  out  DATA_W  pixel (2r, 2c+1)
- input_data_odd_even  out  DATA_W  pixel (2r+1, 2c)
- input_data_odd_odd  out  DATA_W  pixel (2r+1, 2c+1)
- pixel_store_done  out  1  one-cycle pulse when the frame is complete
- frame_ready  out  1  level: a full frame is held and readable
- write_error  out  1  sticky: a write was dropped (out of range, or issued while READY)

Behaviour:
- Reset (asynchronous, immediate): state=FILL, write count=0; all outputs 0. Bank contents are not reset.
- Reset asserted mid-frame discards the frame's progress; the next frame starts from count 0.
- Bank select: {save_row[0], save_col[0]}. Bank index = (save_row>>1)*(IN_DIM/2) + (save_col>>1). Each bank holds (IN_DIM/2)^2 words.
- States:
  - FILL: a write with save_enable=1 and row, col < IN_DIM is stored at the clock edge and increments the count.
    - The write that makes count reach IN_DIM*IN_DIM moves the block to READY and pulses pixel_store_done high for exactly the next cycle.
    - A write with row or col >= IN_DIM is not stored, not counted, and sets write_error.
    - Rewriting the same location overwrites it and still counts. The producer must write each location exactly once per frame.
  - READY: frame_ready=1. Any save_enable is dropped and sets write_error.
    - frame_release=1 returns the block to FILL with count=0 at the next edge. A write in that same cycle is still dropped.
- frame_release while in FILL is ignored.
- Read path, both states:
  - Registered 1-cycle latency: read_pixel_signal=1 at edge N puts the four bank words at pooled (read_row_addr, read_col_addr) on the outputs after edge N.
  - Pooled row or col >= IN_DIM/2 loads zeros.
  - With read_pixel_signal=0, the outputs hold their last value.
  - Reads in FILL return whatever is currently stored, with no ordering guarantee.
- write_error clears only on rst.
- Count register is 16 bits; IN_DIM*IN_DIM must be <= 65535.

Decomposition:
- Shared CNN package holds: DATA_W and IN_DIM defaults for layer 6, state enum {FILL, READY}, and a pooled-dimension constant (IN_DIM/2 - 1, matching the pooling column-end constant).
- One sub-module, pixel_bank_ram: a single bank with synchronous write, registered read, and DEPTH/DATA_W parameters. It is instantiated four times.
- The write counter reuses counter_cnn with the clear/keep convention.

Test Plan:
- Reset, then raster-write a 16x16 frame with data = {8{row*16+col}} -> pixel_store_done high for one cycle after the 256th write; frame_ready=1; write_error=0.
- Read pooled (3,5) -> next cycle ee=pix(6,10)=0x6A, eo=0x6B, oe=0x7A, oo=0x7B in every 16-bit lane. Read pooled (7,7) -> 0xEE, 0xEF, 0xFE, 0xFF.
- Write (0,0) while READY -> bank unchanged (pooled (0,0) still returns ee=0x00), write_error=1.
- Assert frame_release -> frame_ready=0 next cycle. Write a second frame with data+1 -> new pixel_store_done pulse; pooled (0,0) returns ee=0x01.
- Write row=16, col=0 during FILL -> not counted (pixel_store_done still comes only after 256 valid writes), write_error=1. Read pooled (8,0) -> all four outputs 0.
- Assert rst after 100 writes -> outputs 0 immediately. Then 256 writes -> pixel_store_done after the 256th, not after the 156th.
